// File: rtl/oled_request_scheduler.sv
// oled_request_scheduler
//   Sequences an SSD1331 OLED interface for several requesters: power-on,
//   draw, clear and power-off. Requests latch into sticky pending bits and
//   are arbitrated by fixed priority in IDLE. The block drives the
//   interface's mode/start handshake and waits for ready to fall, then rise.
//   It also powers on automatically after reset, can refresh periodically,
//   and times out the handshake.
//
// Ports
//   i_CLK, i_RST_N       clock, asynchronous active-low reset
//   i_REQ_DRAW/CLEAR/OFF request inputs (pulse or level)
//   i_BG_COLOR           requested background colour
//   i_OLED_READY         interface ready (low while an operation runs)
//   o_MODE               00 ON, 01 DRAW, 10 CLEAR, 11 OFF
//   o_START              start strobe, START_CYCLES long
//   o_BG_COLOR           colour latched at grant
//   o_GRANT              one-hot {OFF,CLEAR,DRAW,ON} in service
//   o_BUSY               not IDLE
//   o_POWERED            display on
//   o_DONE / o_TIMEOUT   one-cycle completion / handshake-failure pulses
//
// Optional feature: define OLED_SCHED_COLOR_TRACK_EN to queue a DRAW
//   automatically when i_BG_COLOR differs from the last drawn colour for
//   two consecutive powered IDLE cycles.
module oled_request_scheduler #(
  parameter int N_COLOR_BITS   = 8,
  parameter int START_CYCLES   = 20,
  parameter int ACK_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_REQ_DRAW,
  input  logic                    i_REQ_CLEAR,
  input  logic                    i_REQ_OFF,
  input  logic [N_COLOR_BITS-1:0] i_BG_COLOR,
  input  logic                    i_OLED_READY,
  output logic [1:0]              o_MODE,
  output logic                    o_START,
  output logic [N_COLOR_BITS-1:0] o_BG_COLOR,
  output logic [3:0]              o_GRANT,
  output logic                    o_BUSY,
  output logic                    o_POWERED,
  output logic                    o_DONE,
  output logic                    o_TIMEOUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_COMPLETE,
    S_FAIL
  } state_t;

  localparam int MAX_SA  = (START_CYCLES > ACK_CYCLES) ? START_CYCLES : ACK_CYCLES;
  localparam int CNT_MAX = (MAX_SA > TIMEOUT_CYCLES) ? MAX_SA : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [RW-1:0]  ref_cnt;
  logic           ref_hit;
  logic           track_hit;

  logic           pend_on, pend_draw, pend_clear, pend_off;
  logic [3:0]     grant_n;
  logic [1:0]     mode_n;
  logic           drop_on, drop_off;
  logic           grant_issue;

  // Arbitration. While unpowered, any display work first needs ON; the
  // draw/clear bits stay pending and are served after power-up.
  always_comb begin
    grant_n  = '0;
    mode_n   = 2'b00;
    drop_on  = 1'b0;
    drop_off = 1'b0;
    if (!o_POWERED) begin
      drop_off = pend_off;
      if (pend_on || pend_draw || pend_clear) begin
        grant_n = 4'b0001;
        mode_n  = 2'b00;
      end
    end else begin
      drop_on = pend_on;
      if (pend_off) begin
        grant_n = 4'b1000;
        mode_n  = 2'b11;
      end else if (pend_clear) begin
        grant_n = 4'b0100;
        mode_n  = 2'b10;
      end else if (pend_draw) begin
        grant_n = 4'b0010;
        mode_n  = 2'b01;
      end
    end
  end

  assign grant_issue = (state == S_IDLE) && (grant_n != 4'b0000);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (grant_issue) state_n = S_WAIT_RDY;
      S_WAIT_RDY:  if (i_OLED_READY) state_n = S_START;
      S_START:     if (cnt >= START_LAST) state_n = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!i_OLED_READY)         state_n = S_WAIT_DONE;
        else if (cnt >= ACK_LAST)  state_n = S_FAIL;
      end
      S_WAIT_DONE: begin
        if (i_OLED_READY)          state_n = S_COMPLETE;
        else if (cnt >= TO_LAST)   state_n = S_FAIL;
      end
      S_COMPLETE:  state_n = S_IDLE;
      S_FAIL:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  assign o_START   = (state == S_START);
  assign o_BUSY    = (state != S_IDLE);
  assign o_DONE    = (state == S_COMPLETE);
  assign o_TIMEOUT = (state == S_FAIL);

  // State, wait counter (restarts on every state change, saturates) and
  // the registered operation outputs.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      o_MODE     <= 2'b00;
      o_GRANT    <= '0;
      o_BG_COLOR <= '0;
      o_POWERED  <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)  cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + CW'(1);

      if (grant_issue) begin
        o_MODE     <= mode_n;
        o_GRANT    <= grant_n;
        o_BG_COLOR <= i_BG_COLOR;
      end
      if (state == S_COMPLETE) begin
        if (o_GRANT[0]) o_POWERED <= 1'b1;
        if (o_GRANT[3]) o_POWERED <= 1'b0;
      end
      if (state == S_COMPLETE || state == S_FAIL) o_GRANT <= '0;
    end
  end

  // Pending bits: a same-cycle set always beats a clear, so a request
  // arriving in its own grant cycle is not lost.
  logic clr_on, clr_draw, clr_clear, clr_off;
  logic set_on, set_draw, set_clear, set_off;
  logic failing;

  assign failing   = (state == S_FAIL);
  assign clr_on    = (grant_issue && grant_n[0]) || ((state == S_IDLE) && drop_on);
  assign clr_draw  = grant_issue && grant_n[1];
  assign clr_clear = grant_issue && grant_n[2];
  assign clr_off   = (grant_issue && grant_n[3]) || ((state == S_IDLE) && drop_off);
  assign set_on    = failing && o_GRANT[0];
  assign set_draw  = i_REQ_DRAW  || (failing && o_GRANT[1]) || ref_hit || track_hit;
  assign set_clear = i_REQ_CLEAR || (failing && o_GRANT[2]);
  assign set_off   = i_REQ_OFF   || (failing && o_GRANT[3]);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      pend_on    <= 1'b1;
      pend_draw  <= 1'b0;
      pend_clear <= 1'b0;
      pend_off   <= 1'b0;
    end else begin
      pend_on    <= (pend_on    && !clr_on)    || set_on;
      pend_draw  <= (pend_draw  && !clr_draw)  || set_draw;
      pend_clear <= (pend_clear && !clr_clear) || set_clear;
      pend_off   <= (pend_off   && !clr_off)   || set_off;
    end
  end

  // Refresh timer runs only while powered and restarts from zero on power-up.
  assign ref_hit = (REFRESH_CYCLES > 0) && o_POWERED && (ref_cnt == REF_LAST);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      ref_cnt <= '0;
    end else if (!o_POWERED || (REFRESH_CYCLES == 0) || ref_hit) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

`ifdef OLED_SCHED_COLOR_TRACK_EN
  logic [N_COLOR_BITS-1:0] last_color;
  logic                    diff, diff_q;

  // Two consecutive differing cycles debounce switch inputs; no new set while
  // a draw is already pending, so the grant cycle does not re-arm it.
  assign diff      = (state == S_IDLE) && o_POWERED && (i_BG_COLOR != last_color);
  assign track_hit = diff && diff_q && !pend_draw;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      last_color <= '0;
      diff_q     <= 1'b0;
    end else begin
      diff_q <= diff;
      if (grant_issue && grant_n[1]) last_color <= i_BG_COLOR;
    end
  end
`else
  assign track_hit = 1'b0;
`endif

endmodule

// File: tb/tb_oled_request_scheduler.sv
module tb_oled_request_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, rst_ref_n;
  logic       req_draw, req_clear, req_off, r_req_off;
  logic [7:0] bg;
  logic       ready, r_ready;
  logic       model_hang;

  logic [1:0] mode, r_mode;
  logic       start, r_start;
  logic [7:0] bgo, r_bgo;
  logic [3:0] grant, r_grant;
  logic       busy, r_busy, powered, r_powered, done, r_done, tmo, r_tmo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oled_request_scheduler #(
    .N_COLOR_BITS(8), .START_CYCLES(20), .ACK_CYCLES(64),
    .TIMEOUT_CYCLES(50000000), .REFRESH_CYCLES(0)
  ) dut (
    .i_CLK(clk), .i_RST_N(rst_n),
    .i_REQ_DRAW(req_draw), .i_REQ_CLEAR(req_clear), .i_REQ_OFF(req_off),
    .i_BG_COLOR(bg), .i_OLED_READY(ready),
    .o_MODE(mode), .o_START(start), .o_BG_COLOR(bgo), .o_GRANT(grant),
    .o_BUSY(busy), .o_POWERED(powered), .o_DONE(done), .o_TIMEOUT(tmo)
  );

  oled_request_scheduler #(
    .N_COLOR_BITS(8), .START_CYCLES(20), .ACK_CYCLES(64),
    .TIMEOUT_CYCLES(50000000), .REFRESH_CYCLES(1000)
  ) u_ref (
    .i_CLK(clk), .i_RST_N(rst_ref_n),
    .i_REQ_DRAW(1'b0), .i_REQ_CLEAR(1'b0), .i_REQ_OFF(r_req_off),
    .i_BG_COLOR(8'h5A), .i_OLED_READY(r_ready),
    .o_MODE(r_mode), .o_START(r_start), .o_BG_COLOR(r_bgo), .o_GRANT(r_grant),
    .o_BUSY(r_busy), .o_POWERED(r_powered), .o_DONE(r_done), .o_TIMEOUT(r_tmo)
  );

  // Interface models: ready drops a few cycles after start rises and
  // returns about 100 cycles later; model_hang keeps ready stuck high.
  logic [7:0] mcnt, r_mcnt;
  logic       st_q, r_st_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      ready <= 1'b1; mcnt <= '0; st_q <= 1'b0;
    end else begin
      st_q <= start;
      if (model_hang) ready <= 1'b1;
      else if (start && !st_q) mcnt <= 8'd1;
      else if (mcnt != 8'd0) begin
        if (mcnt == 8'd3) ready <= 1'b0;
        if (mcnt == 8'd103) begin ready <= 1'b1; mcnt <= '0; end
        else mcnt <= mcnt + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_ref_n) begin
      r_ready <= 1'b1; r_mcnt <= '0; r_st_q <= 1'b0;
    end else begin
      r_st_q <= r_start;
      if (r_start && !r_st_q) r_mcnt <= 8'd1;
      else if (r_mcnt != 8'd0) begin
        if (r_mcnt == 8'd3) r_ready <= 1'b0;
        if (r_mcnt == 8'd103) begin r_ready <= 1'b1; r_mcnt <= '0; end
        else r_mcnt <= r_mcnt + 8'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(input int limit, output int n);
    n = 0;
    while (grant == 4'b0000 && n < limit) begin tick(); n++; end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 600) begin tick(); n++; end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    logic [3:0] g;
    logic [7:0] c;
    rst_n = 1'b0; rst_ref_n = 1'b0;
    req_draw = 1'b0; req_clear = 1'b0; req_off = 1'b0; r_req_off = 1'b0;
    bg = 8'h00; model_hang = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_mode", {30'd0, mode}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_bg", {24'd0, bgo}, 32'd0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_powered", {31'd0, powered}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, tmo}, 32'd0);

    // Automatic power-on: grant in cycle 0, start rises in cycle 2, 20 long
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("on_grant", {28'd0, grant}, 32'h1);
    check("on_busy", {31'd0, busy}, 32'd1);
    check("on_start_c1", {31'd0, start}, 32'd0);
    tick();
    check("on_start_c2", {31'd0, start}, 32'd1);
    n = 0;
    while (start && n < 100) begin n++; tick(); end
    check("on_start_len", n, 32'd20);
    wait_done("on_done");
    check("on_mode", {30'd0, mode}, 32'd0);
    tick();
    check("on_done_pulse", {31'd0, done}, 32'd0);
    check("on_powered", {31'd0, powered}, 32'd1);
    check("on_idle", {31'd0, busy}, 32'd0);
    check("on_grant_clr", {28'd0, grant}, 32'd0);

    // DRAW + OFF together: OFF, then ON, then DRAW with E0
    bg = 8'hE0; req_draw = 1'b1; req_off = 1'b1;
    tick();
    req_draw = 1'b0; req_off = 1'b0;
    wait_grant(10, n);
    check("off_grant", {28'd0, grant}, 32'h8);
    check("off_mode", {30'd0, mode}, 32'd3);
    bg = 8'h33;
    wait_done("off_done");
    check("off_bg_stable", {24'd0, bgo}, 32'hE0);
    bg = 8'hE0;
    tick();
    check("off_powered", {31'd0, powered}, 32'd0);
    wait_grant(10, n);
    check("reon_lat", n, 32'd1);
    check("reon_grant", {28'd0, grant}, 32'h1);
    wait_done("reon_done");
    tick();
    check("reon_powered", {31'd0, powered}, 32'd1);
    wait_grant(10, n);
    check("draw_grant", {28'd0, grant}, 32'h2);
    check("draw_mode", {30'd0, mode}, 32'd1);
    check("draw_bg", {24'd0, bgo}, 32'hE0);
    wait_done("draw_done");
    tick();

    // Ack timeout 64 cycles after start falls, then retry
    model_hang = 1'b1;
    req_clear = 1'b1;
    tick();
    req_clear = 1'b0;
    wait_grant(10, n);
    check("to_grant", {28'd0, grant}, 32'h4);
    n = 0;
    while (!start && n < 10) begin tick(); n++; end
    n = 0;
    while (start && n < 40) begin tick(); n++; end
    n = 0;
    while (!tmo && n < 200) begin tick(); n++; end
    check("to_latency", n, 32'd64);
    check("to_grant_hold", {28'd0, grant}, 32'h4);
    check("to_no_done", {31'd0, done}, 32'd0);
    model_hang = 1'b0;
    tick();
    check("to_pulse", {31'd0, tmo}, 32'd0);
    check("to_grant_clr", {28'd0, grant}, 32'd0);
    wait_grant(10, n);
    check("retry_lat", n, 32'd1);
    check("retry_grant", {28'd0, grant}, 32'h4);
    wait_done("retry_done");
    tick();

    // CLEAR held through its own operation: one more CLEAR right after
    req_clear = 1'b1;
    wait_grant(10, n);
    check("hold_grant1", {28'd0, grant}, 32'h4);
    wait_done("hold_done1");
    req_clear = 1'b0;
    tick();
    wait_grant(10, n);
    check("hold_lat2", n, 32'd1);
    check("hold_grant2", {28'd0, grant}, 32'h4);
    wait_done("hold_done2");
    tick();
    n = 0;
    repeat (20) begin tick(); if (grant != 4'b0000) n++; end
    check("hold_no_third", n, 32'd0);

    // Colour tracking
    bg = 8'h1C;
    g = 4'b0000; c = 8'h00;
    repeat (12) begin
      tick();
      if (grant != 4'b0000 && g == 4'b0000) begin g = grant; c = bgo; end
    end
`ifdef OLED_SCHED_COLOR_TRACK_EN
    check("track_grant", {28'd0, g}, 32'h2);
    check("track_bg", {24'd0, c}, 32'h1C);
    wait_done("track_done");
`else
    check("track_none", {28'd0, g}, 32'd0);
`endif

    // Refresh instance: DRAW 1001 samples after power-up, none once off
    @(negedge clk) rst_ref_n = 1'b1;
    n = 0;
    while (!r_done && n < 600) begin tick(); n++; end
    check("ref_on_done", {31'd0, r_done}, 32'd1);
    tick();
    check("ref_powered", {31'd0, r_powered}, 32'd1);
    n = 0;
    while (r_grant == 4'b0000 && n < 2000) begin tick(); n++; end
    check("ref_period", n, 32'd1001);
    check("ref_grant", {28'd0, r_grant}, 32'h2);
    n = 0;
    while (!r_done && n < 600) begin tick(); n++; end
    tick();
    r_req_off = 1'b1;
    tick();
    r_req_off = 1'b0;
    n = 0;
    while (r_grant == 4'b0000 && n < 10) begin tick(); n++; end
    check("ref_off_grant", {28'd0, r_grant}, 32'h8);
    n = 0;
    while (!r_done && n < 600) begin tick(); n++; end
    tick();
    check("ref_off_powered", {31'd0, r_powered}, 32'd0);
    n = 0;
    repeat (1200) begin tick(); if (r_grant != 4'b0000) n++; end
    check("ref_none_off", n, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oled_request_scheduler.md
Name: oled_request_scheduler

Overview:
- Sequences the SSD1331 OLED interface on behalf of several requesters: power-on, draw (text + background), clear and power-off.
- Latches requests as sticky pending bits and arbitrates them by fixed priority. Drives the interface's mode/start handshake and waits for its ready line to fall and then rise.
- Adds automatic power-on after reset, periodic refresh and a handshake timeout.
- Sits between board-level buttons/switches/user logic and the OLED interface's i_MODE / i_START / i_BACKGROUND_COLOR / o_READY pins.

Parameters:
- N_COLOR_BITS, 8, width of background colour bus.
- START_CYCLES, 20, o_START high time in i_CLK cycles, so the slower interface clock samples it.
- ACK_CYCLES, 64, max cycles after o_START falls for i_OLED_READY to drop.
- TIMEOUT_CYCLES, 50000000, max cycles for i_OLED_READY to return high once busy.
- REFRESH_CYCLES, 0, auto-refresh period in cycles; 0 disables auto-refresh.

Ports:
- i_CLK, input, 1, system clock.
- i_RST_N, input, 1, asynchronous active-low reset.
- i_REQ_DRAW, input, 1, request redraw of text/background; any-cycle pulse or level.
- i_REQ_CLEAR, input, 1, request clear screen.
- i_REQ_OFF, input, 1, request power-off sequence.
- i_BG_COLOR, input, N_COLOR_BITS, requested background colour.
- i_OLED_READY, input, 1, ready from OLED interface; low while an operation is running.
- o_MODE, output, 2, mode to interface: 00 ON, 01 DRAW, 10 CLEAR, 11 OFF.
- o_START, output, 1, start strobe to interface.
- o_BG_COLOR, output, N_COLOR_BITS, colour latched at grant; stable for the whole operation.
- o_GRANT, output, 4, one-hot operation in service; bit order {OFF,CLEAR,DRAW,ON}.
- o_BUSY, output, 1, high in any state other than IDLE.
- o_POWERED, output, 1, display is on: set after ON completes, cleared after OFF completes.
- o_DONE, output, 1, one-cycle pulse when an operation completes.
- o_TIMEOUT, output, 1, one-cycle pulse on handshake failure.

Behaviour:
- Reset (async, i_RST_N=0) sets:
  - outputs: o_MODE=00, o_START=0, o_BG_COLOR=0, o_GRANT=0, o_BUSY=0, o_POWERED=0, o_DONE=0, o_TIMEOUT=0;
  - internal state: pending_on=1, other pending bits=0, all counters=0, state=IDLE.
- Pending bits:
  - Any cycle with a req input high sets the matching pending bit.
  - A pending bit clears on the cycle its grant is issued. A request in that same cycle wins, so the bit stays set.
- Arbitration, evaluated only in IDLE:
  - pending_off is granted only if o_POWERED=1. If o_POWERED=0 it is silently dropped.
  - If o_POWERED=0 and any of pending_draw, pending_clear or pending_on is set, grant ON. The draw/clear bits stay pending.
  - Otherwise priority is OFF > CLEAR > DRAW.
  - A pending ON while already powered is dropped.
- States:
  - IDLE: choose grant; latch o_MODE, o_GRANT and o_BG_COLOR=i_BG_COLOR; go to WAIT_RDY.
  - WAIT_RDY: wait for i_OLED_READY=1 (no timeout); go to START.
  - START: o_START=1 for exactly START_CYCLES cycles; go to WAIT_ACK.
  - WAIT_ACK: i_OLED_READY=0 goes to WAIT_DONE. ACK_CYCLES elapsed goes to FAIL.
  - WAIT_DONE: i_OLED_READY=1 goes to COMPLETE. TIMEOUT_CYCLES elapsed goes to FAIL.
  - COMPLETE, one cycle: o_DONE=1; update o_POWERED for ON/OFF; o_GRANT=0; go to IDLE.
  - FAIL, one cycle: o_TIMEOUT=1; re-set the pending bit of the failed op; o_POWERED unchanged; o_GRANT=0; go to IDLE.
- Minimum latency from IDLE grant to o_START rise is 2 cycles when ready is already high.
- Back-to-back operations: after COMPLETE, the next grant is evaluated in the following IDLE cycle.
- Refresh counter:
  - Runs only while o_POWERED=1 and REFRESH_CYCLES>0.
  - Wraps at REFRESH_CYCLES-1 and on wrap sets pending_draw.
  - Cleared when o_POWERED falls.
- Counters are sized with $clog2 of their limit and saturate; no wrap inside a wait state.
- i_BG_COLOR changes mid-operation do not affect o_BG_COLOR until the next grant.

Optional Feature:
- Macro OLED_SCHED_COLOR_TRACK_EN.
- Defined:
  - A register holds the last colour granted for DRAW.
  - While o_POWERED=1 and in IDLE, i_BG_COLOR differing from that register for 2 consecutive cycles (debounce for switch inputs) sets pending_draw.
  - The register resets to 0.
- Undefined: colour is sampled only at grant; no automatic draw; the register is absent.

Test Plan:
- Reset release, i_OLED_READY=1, interface model drops ready 3 cycles after start and raises it 100 cycles later -> o_MODE=00, o_START high 20 cycles starting cycle 2, o_DONE pulse, o_POWERED=1, o_BUSY=0.
- Powered; pulse i_REQ_DRAW and i_REQ_OFF in the same cycle with i_BG_COLOR=8'hE0 -> OFF served first (o_GRANT=4'b1000); then ON (o_MODE=00) re-powers; then DRAW with o_BG_COLOR=8'hE0.
- Interface model never drops ready -> o_TIMEOUT pulse 64 cycles after o_START falls; pending bit restored; retry occurs on the next IDLE.
- REFRESH_CYCLES=1000, powered, no requests -> DRAW grant every 1000 cycles plus service time; none after an OFF completes.
- i_REQ_CLEAR held high through a CLEAR operation -> a second CLEAR is served immediately after the first completes.
- With OLED_SCHED_COLOR_TRACK_EN: change i_BG_COLOR 8'h00->8'h1C for 2 cycles -> one DRAW with o_BG_COLOR=8'h1C. Without the macro -> no operation.
